au_seq_ctrl: RTL and testbench

Multi-cycle sequencing controller for the 32-bit arithmetic unit. It accepts one ADD/SUB/MULT/DIV request at a time over a valid/ready handshake and runs ADD/SUB in a single step. MULT uses iterative shift-add and DIV uses restoring division, one bit per cycle. Results are presented on registered s/hi/lo/zero outputs with a one-cycle done pulse. It sits between the issuing control logic and the result consumers (register file / hi-lo write-back).

---
 rtl/au_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_au_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_seq_ctrl.sv
// au_seq_ctrl -- multi-cycle sequencing controller for the arithmetic unit.
//
// Accepts one ADD/SUB/MULT/DIV request at a time over a valid/ready handshake.
// ADD/SUB finish in one step. MULT (unsigned shift-add) and DIV (unsigned
// restoring) iterate one bit per cycle for WIDTH cycles. Results are held in
// registered s/hi/lo/zero outputs and announced with a one-cycle done pulse.
//
// Optional build macro: AU_SEQ_DIV0_EN
//   When defined, a div0 port is added. A DIV with b==0 then skips the
//   iterations and completes with ADD latency.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  controller can accept (IDLE and not in reset)
//   a, b       operands, sampled on accept
//   ALUop      00 ADD, 01 SUB, 10 MULT, 11 DIV, sampled on accept
//   busy       high in RUN and DONE
//   done       one-cycle completion pulse
//   s          ADD/SUB result
//   hi, lo     MULT product halves / DIV remainder and quotient
//   zero       zero flag of the last completed op
//   div0       divide-by-zero flag (AU_SEQ_DIV0_EN only)
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | MULT/DIV iterating, one bit per cycle
// DONE  | result registers just updated, done pulse

module au_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ALUop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero
`ifdef AU_SEQ_DIV0_EN
    ,
    output logic             div0
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic               op_div;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] p, p_nxt;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [WIDTH-1:0]   addsub;
    logic               accept, div_by0;

    assign accept = (state == IDLE) && req_valid && !rst;
    assign addsub = ALUop[0] ? (a - b) : (a + b);

`ifdef AU_SEQ_DIV0_EN
    assign div_by0 = (ALUop == 2'b11) && (b == '0);
`else
    assign div_by0 = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst)
                    state_nxt = (ALUop[1] && !div_by0) ? RUN : DONE;
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p holds {upper, lower}: the product for MULT, {R, Q} for DIV.
    // The divide trial uses WIDTH+1 bits because the shifted remainder can
    // exceed WIDTH bits; bit WIDTH of the difference is the borrow.
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_r} : '0);
        div_trial = p[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, b_r};
        if (!op_div)
            p_nxt = {mul_sum, p[WIDTH-1:1]};
        else if (!div_diff[WIDTH])
            p_nxt = {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        else
            p_nxt = {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            op_div <= 1'b0;
            b_r    <= '0;
            p      <= '0;
            s      <= '0;
            hi     <= '0;
            lo     <= '0;
            zero   <= 1'b0;
`ifdef AU_SEQ_DIV0_EN
            div0   <= 1'b0;
`endif
        end else if (accept) begin
            count  <= '0;
            op_div <= ALUop[0];
            b_r    <= b;
            p      <= {{WIDTH{1'b0}}, a};
            if (!ALUop[1]) begin
                s    <= addsub;
                zero <= (addsub == '0);
`ifdef AU_SEQ_DIV0_EN
                div0 <= 1'b0;
`endif
            end
`ifdef AU_SEQ_DIV0_EN
            else if (div_by0) begin
                hi   <= a;
                lo   <= '1;
                zero <= 1'b0;
                div0 <= 1'b1;
            end
`endif
        end else if (state == RUN) begin
            p <= p_nxt;
            if (count != LAST) begin
                count <= count + CW'(1);
            end else begin
                {hi, lo} <= p_nxt;
                zero     <= op_div ? (p_nxt[WIDTH-1:0] == '0) : (p_nxt == '0);
`ifdef AU_SEQ_DIV0_EN
                div0     <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_au_seq_ctrl.sv
module tb_au_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   ALUop = 2'b00;
    logic         req_ready, busy, done, zero;
    logic [W-1:0] s, hi, lo;
`ifdef AU_SEQ_DIV0_EN
    logic         div0;
`endif

    int checks = 0;
    int errors = 0;

    au_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .b(b), .ALUop(ALUop), .busy(busy), .done(done),
        .s(s), .hi(hi), .lo(lo), .zero(zero)
`ifdef AU_SEQ_DIV0_EN
        , .div0(div0)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs for the current cycle, built from
    // plain arithmetic and a countdown of cycles until the done pulse.
    bit           m_done = 0;
    int           m_left = 0;
    logic [W-1:0] m_s = '0, m_hi = '0, m_lo = '0;
    logic         m_zero = 0;
    logic [W-1:0] p_s, p_hi, p_lo;
    logic         p_zero;
`ifdef AU_SEQ_DIV0_EN
    logic         m_div0 = 0, p_div0;
`endif

    task automatic commit();
        m_done = 1; m_s = p_s; m_hi = p_hi; m_lo = p_lo; m_zero = p_zero;
`ifdef AU_SEQ_DIV0_EN
        m_div0 = p_div0;
`endif
    endtask

    task automatic model_step();
        logic [63:0] prod;
        int lat;
        if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) commit();
        end else if (req_valid) begin
            p_s = m_s; p_hi = m_hi; p_lo = m_lo; p_zero = m_zero;
            lat = W + 1;
`ifdef AU_SEQ_DIV0_EN
            p_div0 = 0;
`endif
            case (ALUop)
                2'b00: begin p_s = a + b; p_zero = (p_s == 0); lat = 1; end
                2'b01: begin p_s = a - b; p_zero = (p_s == 0); lat = 1; end
                2'b10: begin
                    prod = 64'(a) * 64'(b);
                    p_hi = prod[63:32]; p_lo = prod[31:0];
                    p_zero = (prod == 0);
                end
                default: begin
                    if (b == 0) begin p_hi = a; p_lo = '1; end
                    else begin p_lo = a / b; p_hi = a % b; end
                    p_zero = (p_lo == 0);
`ifdef AU_SEQ_DIV0_EN
                    if (b == 0) begin lat = 1; p_div0 = 1; end
`endif
                end
            endcase
            if (lat == 1) commit();
            else m_left = lat - 1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_done = 0; m_left = 0; m_s = '0; m_hi = '0; m_lo = '0; m_zero = 0;
`ifdef AU_SEQ_DIV0_EN
            m_div0 = 0;
`endif
        end
        chk("done", done, m_done);
        chk("busy", busy, m_done || (m_left > 0));
        chk("req_ready", req_ready, !rst && !m_done && (m_left == 0));
        chk("s", s, m_s);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("zero", zero, m_zero);
`ifdef AU_SEQ_DIV0_EN
        chk("div0", div0, m_div0);
`endif
        if (!rst) model_step();
    end

    // Drive a request once ready; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] op);
        int n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
        req_valid = 1; a = av; b = bv; ALUop = op;
        @(posedge clk); #1;
        req_valid = 0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] op,
                         output int n);
        start_op(av, bv, op);
        wait_done(n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_s", s, 0);
        @(posedge clk); #1 rst = 0;

        do_op(5, 7, 2'b00, lat);
        chk("add_lat", lat, 1);
        chk("add_s", s, 12);
        chk("add_zero", zero, 0);
        chk("model_add_s", m_s, 12);
        @(negedge clk);
        chk("add_ready_t2", req_ready, 1);

        do_op(5, 5, 2'b01, lat);
        chk("sub_s", s, 0);
        chk("sub_zero", zero, 1);

        do_op(32'hFFFF_FFFF, 2, 2'b10, lat);
        chk("mult_lat", lat, 33);
        chk("mult_hi", hi, 1);
        chk("mult_lo", lo, 32'hFFFF_FFFE);
        chk("mult_zero", zero, 0);
        chk("model_mult_lo", m_lo, 32'hFFFF_FFFE);

        do_op(0, 1, 2'b01, lat);
        chk("sub2_s", s, 32'hFFFF_FFFF);
        chk("sub2_zero", zero, 0);
        chk("sub2_hi_hold", hi, 1);
        chk("sub2_lo_hold", lo, 32'hFFFF_FFFE);

        do_op(0, 9, 2'b10, lat);
        chk("mult0_hi", hi, 0);
        chk("mult0_lo", lo, 0);
        chk("mult0_zero", zero, 1);

        do_op(100, 7, 2'b11, lat);
        chk("div_lat", lat, 33);
        chk("div_lo", lo, 14);
        chk("div_hi", hi, 2);
        chk("div_s_hold", s, 32'hFFFF_FFFF);
        chk("model_div_hi", m_hi, 2);

        do_op(3, 7, 2'b11, lat);
        chk("div2_lo", lo, 0);
        chk("div2_hi", hi, 3);
        chk("div2_zero", zero, 1);

        // New requests held during RUN must be ignored.
        start_op(6, 7, 2'b10);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1; a = $urandom; b = $urandom; ALUop = 2'($urandom);
            @(negedge clk);
            chk("hold_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        req_valid = 0;
        wait_done(lat);
        chk("hold_lo", lo, 42);
        chk("hold_hi", hi, 0);

        // Reset in the middle of a MULT.
        start_op(32'h0000_FFFF, 32'h0000_FFFF, 2'b10);
        repeat (9) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_s", s, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end
        do_op(1, 1, 2'b00, lat);
        chk("post_rst_add", s, 2);

        do_op(32'h1234, 0, 2'b11, lat);
        chk("div0_hi", hi, 32'h1234);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_zero", zero, 0);
`ifdef AU_SEQ_DIV0_EN
        chk("div0_lat", lat, 1);
        chk("div0_flag", div0, 1);
        do_op(1, 2, 2'b00, lat);
        chk("div0_clear", div0, 0);
`else
        chk("div0_lat", lat, 33);
`endif

        // Random traffic, including requests while busy and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (rst) rst = 0;
            else if ($urandom_range(0, 299) == 0) rst = 1;
            req_valid = ($urandom_range(0, 2) != 0);
            ALUop = 2'($urandom);
            case ($urandom_range(0, 5))
                0: a = 0;
                1: a = '1;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = '1;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
        end
        @(posedge clk); #1;
        rst = 0; req_valid = 0;
        repeat (40) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
